// File: rtl/max31855_multi_reader.sv
// Multi-channel MAX31855 reader: sweeps N_CH devices on a shared SCK/MISO bus, emits frames on a ready/valid stream.
// Optional build macro MAX_FAULT_RETRY_EN re-reads a faulted (D16 set, not absent) frame once before emitting it.
module max31855_multi_reader #(
  parameter int N_CH          = 4,
  parameter int CLK_DIV       = 10,
  parameter int SAMPLE_PERIOD = 1000000,
  localparam int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             SPI_clk,
  output logic [N_CH-1:0]  SPI_cs,
  input  logic             SPI_Data_In,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [CH_W-1:0]  rd_ch,
  output logic [31:0]      rd_data,
  output logic             rd_fault,
  output logic             rd_absent,
  output logic             busy,
  output logic             overrun
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CS_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT    = 3'd2;
  localparam logic [2:0] ST_CS_HOLD  = 3'd3;
  localparam logic [2:0] ST_OUTPUT   = 3'd4;
  localparam logic [2:0] ST_CS_GAP   = 3'd5;

`ifdef MAX_FAULT_RETRY_EN
  localparam logic RETRY_EN = 1'b1;
`else
  localparam logic RETRY_EN = 1'b0;
`endif

  // A floating MISO reads as all ones; such a frame is never reported as a fault.
  function automatic logic frame_absent(input logic [31:0] f);
    return (f == 32'hFFFF_FFFF);
  endfunction

  function automatic logic frame_fault(input logic [31:0] f);
    return f[16] & ~frame_absent(f);
  endfunction

  function automatic logic [N_CH-1:0] cs_select_n(input logic [CH_W-1:0] ch);
    logic [N_CH-1:0] m;
    m = '1;
    m[ch] = 1'b0;
    return m;
  endfunction

  logic [2:0]      state_r, state_n;
  logic [CH_W-1:0] ch_r, ch_n;
  logic [DW-1:0]   div_r, div_n;
  logic [5:0]      half_r, half_n;
  logic [31:0]     shift_r;
  logic [PW-1:0]   period_r;
  logic            pending_r, pending_n;
  logic            retry_pend_r, retry_pend_n;
  logic            retried_r, retried_n;
  logic            valid_n, load_s, overrun_n;
  logic            div_done_s, tick_s, req_s, busy_s, launch_s, shift_en_s, cs_active_s;

  logic [N_CH-1:0] cs_r;
  logic            sck_r, valid_r, fault_r, absent_r, busy_r, overrun_r;
  logic [CH_W-1:0] rdch_r;
  logic [31:0]     data_r;

  assign div_done_s = (div_r == DW'(CLK_DIV - 1));
  assign tick_s     = (period_r == PW'(SAMPLE_PERIOD - 1));
  assign req_s      = start | tick_s;
  assign busy_s     = (state_r != ST_IDLE);
  assign launch_s   = ~busy_s & (req_s | pending_r);

  // Sweep request bookkeeping: one pending slot, a further request while it is full is an overrun.
  always_comb begin
    pending_n = pending_r;
    overrun_n = 1'b0;
    if (busy_s) begin
      if (req_s) begin
        if (pending_r) begin
          overrun_n = 1'b1;
        end else begin
          pending_n = 1'b1;
        end
      end else begin
        pending_n = pending_r;
      end
    end else begin
      pending_n = 1'b0;
    end
  end

  // Sweep FSM next-state; div_r times every CLK_DIV phase, half_r counts the 64 SCK half-periods.
  always_comb begin
    state_n      = state_r;
    ch_n         = ch_r;
    div_n        = div_r + DW'(1);
    half_n       = half_r;
    valid_n      = valid_r;
    load_s       = 1'b0;
    retry_pend_n = retry_pend_r;
    retried_n    = retried_r;
    case (state_r)
      ST_IDLE: begin
        div_n        = '0;
        half_n       = 6'd0;
        retry_pend_n = 1'b0;
        retried_n    = 1'b0;
        if (launch_s) begin
          state_n = ST_CS_SETUP;
          ch_n    = '0;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_CS_SETUP: begin
        if (div_done_s) begin
          state_n = ST_SHIFT;
          div_n   = '0;
          half_n  = 6'd0;
        end else begin
          state_n = ST_CS_SETUP;
        end
      end
      ST_SHIFT: begin
        if (div_done_s) begin
          div_n = '0;
          if (half_r == 6'd63) begin
            state_n = ST_CS_HOLD;
          end else begin
            half_n = half_r + 6'd1;
          end
        end else begin
          state_n = ST_SHIFT;
        end
      end
      ST_CS_HOLD: begin
        if (div_done_s) begin
          div_n = '0;
          if (RETRY_EN && frame_fault(shift_r) && !retried_r) begin
            retry_pend_n = 1'b1;
            state_n      = ST_CS_GAP;
          end else begin
            load_s  = 1'b1;
            valid_n = 1'b1;
            state_n = ST_OUTPUT;
          end
        end else begin
          state_n = ST_CS_HOLD;
        end
      end
      ST_OUTPUT: begin
        div_n = '0;
        if (rd_ready) begin
          valid_n = 1'b0;
          state_n = ST_CS_GAP;
        end else begin
          state_n = ST_OUTPUT;
        end
      end
      ST_CS_GAP: begin
        if (div_done_s) begin
          div_n = '0;
          if (retry_pend_r) begin
            retry_pend_n = 1'b0;
            retried_n    = 1'b1;
            state_n      = ST_CS_SETUP;
          end else if (ch_r == CH_W'(N_CH - 1)) begin
            retried_n = 1'b0;
            state_n   = ST_IDLE;
          end else begin
            retried_n = 1'b0;
            ch_n      = ch_r + CH_W'(1);
            state_n   = ST_CS_SETUP;
          end
        end else begin
          state_n = ST_CS_GAP;
        end
      end
      default: begin
        state_n = ST_IDLE;
        div_n   = '0;
        valid_n = 1'b0;
      end
    endcase
  end

  // MISO is captured on the edge that raises SCK, i.e. at the start of every even half-period.
  assign shift_en_s  = (state_n == ST_SHIFT) && !half_n[0] && (div_n == '0);
  assign cs_active_s = (state_n == ST_CS_SETUP) || (state_n == ST_SHIFT) || (state_n == ST_CS_HOLD);

  // State and registered outputs; all SPI pins follow the next state so they change with it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      ch_r         <= '0;
      div_r        <= '0;
      half_r       <= 6'd0;
      shift_r      <= 32'd0;
      period_r     <= '0;
      pending_r    <= 1'b0;
      retry_pend_r <= 1'b0;
      retried_r    <= 1'b0;
      cs_r         <= '1;
      sck_r        <= 1'b0;
      valid_r      <= 1'b0;
      data_r       <= 32'd0;
      rdch_r       <= '0;
      fault_r      <= 1'b0;
      absent_r     <= 1'b0;
      busy_r       <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      state_r      <= state_n;
      ch_r         <= ch_n;
      div_r        <= div_n;
      half_r       <= half_n;
      period_r     <= tick_s ? '0 : period_r + PW'(1);
      pending_r    <= pending_n;
      retry_pend_r <= retry_pend_n;
      retried_r    <= retried_n;
      if (shift_en_s) begin
        shift_r <= {shift_r[30:0], SPI_Data_In};
      end
      cs_r      <= cs_active_s ? cs_select_n(ch_n) : '1;
      sck_r     <= (state_n == ST_SHIFT) && !half_n[0];
      valid_r   <= valid_n;
      if (load_s) begin
        data_r   <= shift_r;
        rdch_r   <= ch_r;
        fault_r  <= frame_fault(shift_r);
        absent_r <= frame_absent(shift_r);
      end
      busy_r    <= (state_n != ST_IDLE);
      overrun_r <= overrun_n;
    end
  end

  assign SPI_cs    = cs_r;
  assign SPI_clk   = sck_r;
  assign rd_valid  = valid_r;
  assign rd_data   = data_r;
  assign rd_ch     = rdch_r;
  assign rd_fault  = fault_r;
  assign rd_absent = absent_r;
  assign busy      = busy_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_max31855_multi_reader.sv
// Directed bench for max31855_multi_reader: device models on the shared bus, one task per scenario.
module tb_max31855_multi_reader;

  localparam int N_CH    = 4;
  localparam int CLK_DIV = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            SPI_clk;
  logic [N_CH-1:0] SPI_cs;
  logic            miso;
  logic            rd_valid;
  logic            rd_ready = 1'b0;
  logic [1:0]      rd_ch;
  logic [31:0]     rd_data;
  logic            rd_fault, rd_absent, busy, overrun;

  logic            reset_p = 1'b0;
  logic            start_p = 1'b0;
  logic            sck_p;
  logic [N_CH-1:0] cs_p;
  logic            miso_p = 1'b0;
  logic            valid_p;
  logic            ready_p = 1'b0;
  logic [1:0]      ch_p;
  logic [31:0]     data_p;
  logic            fault_p, absent_p, busy_p, overrun_p;

  int errors = 0;
  int checks = 0;

  max31855_multi_reader #(.N_CH(N_CH), .CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(1000000)) dut (
    .clk(clk), .reset(reset), .start(start), .SPI_clk(SPI_clk), .SPI_cs(SPI_cs),
    .SPI_Data_In(miso), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_ch(rd_ch),
    .rd_data(rd_data), .rd_fault(rd_fault), .rd_absent(rd_absent), .busy(busy), .overrun(overrun)
  );

  max31855_multi_reader #(.N_CH(N_CH), .CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(1000)) dut_p (
    .clk(clk), .reset(reset_p), .start(start_p), .SPI_clk(sck_p), .SPI_cs(cs_p),
    .SPI_Data_In(miso_p), .rd_valid(valid_p), .rd_ready(ready_p), .rd_ch(ch_p),
    .rd_data(data_p), .rd_fault(fault_p), .rd_absent(absent_p), .busy(busy_p), .overrun(overrun_p)
  );

  // Device models: load on CS fall (D31 first), shift on SCK fall, count CS-low windows.
  logic [31:0]     dev_val [N_CH];
  logic [31:0]     dev_sr  [N_CH];
  int              cs_fall_cnt [N_CH];
  logic [N_CH-1:0] force_high = '0;
  logic [N_CH-1:0] cs_prev = '1;
  logic            sck_prev = 1'b0;
  logic            cnt_clr = 1'b0;

  always @(negedge clk) begin
    cs_prev  <= SPI_cs;
    sck_prev <= SPI_clk;
    for (int i = 0; i < N_CH; i++) begin
      if (cnt_clr) cs_fall_cnt[i] <= 0;
      else if (cs_prev[i] && !SPI_cs[i]) cs_fall_cnt[i] <= cs_fall_cnt[i] + 1;
      if (cs_prev[i] && !SPI_cs[i]) dev_sr[i] <= dev_val[i];
      else if (!SPI_cs[i] && sck_prev && !SPI_clk) dev_sr[i] <= {dev_sr[i][30:0], 1'b1};
    end
  end

  always_comb begin
    miso = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (!SPI_cs[i]) miso = force_high[i] ? 1'b1 : dev_sr[i][31];
    end
  end

  task automatic wait_valid(input int budget, output bit ok);
    int n;
    n = 0;
    while (!rd_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = rd_valid;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_counts();
    cnt_clr = 1'b1;
    repeat (2) @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; rd_ready = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (SPI_cs !== 4'hF) begin errors++; $display("FAIL reset_cs got=%h exp=f", SPI_cs); end
    checks++; if (SPI_clk !== 1'b0) begin errors++; $display("FAIL reset_sck got=%b exp=0", SPI_clk); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rd_valid); end
    checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", rd_data); end
    checks++; if (rd_ch !== 2'd0) begin errors++; $display("FAIL reset_ch got=%0d exp=0", rd_ch); end
    checks++; if ({rd_fault, rd_absent} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {rd_fault, rd_absent}); end
    checks++; if ({busy, overrun} !== 2'b00) begin errors++; $display("FAIL reset_busy_ovr got=%b exp=00", {busy, overrun}); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sweep();
    bit ok;
    int n, lat;
    for (int i = 0; i < N_CH; i++) dev_val[i] = 32'h0190_0190 + 32'(i);
    force_high = '0;
    rd_ready = 1'b1;
    clear_counts();
    pulse_start();
    n = 0;
    while (SPI_cs[0] && n < 100) begin @(negedge clk); n++; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sweep_busy got=%b exp=1", busy); end
    lat = 0;
    while (!rd_valid && lat < 2000) begin @(negedge clk); lat++; end
    checks++; if (lat != 660) begin errors++; $display("FAIL sweep_latency got=%0d exp=660", lat); end
    for (int k = 0; k < N_CH; k++) begin
      wait_valid(800, ok);
      checks++; if (!ok) begin errors++; $display("FAIL sweep_timeout ch=%0d got=0 exp=1", k); end
      checks++; if (rd_ch !== 2'(k)) begin errors++; $display("FAIL sweep_ch got=%0d exp=%0d", rd_ch, k); end
      checks++; if (rd_data !== 32'h0190_0190 + 32'(k)) begin errors++; $display("FAIL sweep_data got=%h exp=%h", rd_data, 32'h0190_0190 + 32'(k)); end
      checks++; if ({rd_fault, rd_absent} !== 2'b00) begin errors++; $display("FAIL sweep_flags ch=%0d got=%b exp=00", k, {rd_fault, rd_absent}); end
      @(negedge clk);
    end
    repeat (CLK_DIV + 2) @(negedge clk);
    checks++; if ({busy, rd_valid} !== 2'b00) begin errors++; $display("FAIL sweep_done got=%b exp=00", {busy, rd_valid}); end
    checks++; if (cs_fall_cnt[3] != 1) begin errors++; $display("FAIL sweep_windows got=%0d exp=1", cs_fall_cnt[3]); end
  endtask

  task automatic test_fault();
    bit ok;
    int exp_win;
`ifdef MAX_FAULT_RETRY_EN
    exp_win = 2;
`else
    exp_win = 1;
`endif
    dev_val[2] = 32'h0001_0001;
    rd_ready = 1'b1;
    clear_counts();
    pulse_start();
    for (int k = 0; k < N_CH; k++) begin
      wait_valid(2000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL fault_timeout ch=%0d got=0 exp=1", k); end
      checks++; if (rd_ch !== 2'(k)) begin errors++; $display("FAIL fault_ch got=%0d exp=%0d", rd_ch, k); end
      checks++; if (rd_fault !== (k == 2)) begin errors++; $display("FAIL fault_flag ch=%0d got=%b exp=%b", k, rd_fault, (k == 2)); end
      if (k == 2) begin
        checks++; if (rd_data !== 32'h0001_0001) begin errors++; $display("FAIL fault_data got=%h exp=00010001", rd_data); end
      end
      @(negedge clk);
    end
    repeat (CLK_DIV + 2) @(negedge clk);
    checks++; if ({busy, rd_valid} !== 2'b00) begin errors++; $display("FAIL fault_done got=%b exp=00", {busy, rd_valid}); end
    checks++; if (cs_fall_cnt[2] != exp_win) begin errors++; $display("FAIL fault_windows got=%0d exp=%0d", cs_fall_cnt[2], exp_win); end
    checks++; if (cs_fall_cnt[1] != 1) begin errors++; $display("FAIL fault_windows_ch1 got=%0d exp=1", cs_fall_cnt[1]); end
    dev_val[2] = 32'h0190_0192;
  endtask

  task automatic test_absent();
    bit ok;
    force_high[1] = 1'b1;
    rd_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < N_CH; k++) begin
      wait_valid(800, ok);
      checks++; if (!ok) begin errors++; $display("FAIL absent_timeout ch=%0d got=0 exp=1", k); end
      if (k == 1) begin
        checks++; if (rd_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL absent_data got=%h exp=ffffffff", rd_data); end
        checks++; if ({rd_absent, rd_fault} !== 2'b10) begin errors++; $display("FAIL absent_flags got=%b exp=10", {rd_absent, rd_fault}); end
      end else begin
        checks++; if (rd_absent !== 1'b0) begin errors++; $display("FAIL absent_other ch=%0d got=%b exp=0", k, rd_absent); end
      end
      @(negedge clk);
    end
    repeat (CLK_DIV + 2) @(negedge clk);
    force_high = '0;
  endtask

  task automatic test_stall();
    bit ok, hold_bad, sck_bad, cs_bad;
    int n;
    logic [31:0] d0;
    rd_ready = 1'b0;
    pulse_start();
    wait_valid(800, ok);
    checks++; if (!ok || rd_ch !== 2'd0) begin errors++; $display("FAIL stall_first got=%b/%0d exp=1/0", ok, rd_ch); end
    d0 = rd_data;
    hold_bad = 1'b0; sck_bad = 1'b0; cs_bad = 1'b0;
    repeat (5000) begin
      @(negedge clk);
      if (!rd_valid || rd_data !== d0 || rd_ch !== 2'd0) hold_bad = 1'b1;
      if (SPI_clk !== 1'b0) sck_bad = 1'b1;
      if (SPI_cs !== 4'hF) cs_bad = 1'b1;
    end
    checks++; if (hold_bad) begin errors++; $display("FAIL stall_hold got=changed exp=stable"); end
    checks++; if (sck_bad) begin errors++; $display("FAIL stall_sck got=active exp=low"); end
    checks++; if (cs_bad) begin errors++; $display("FAIL stall_cs got=asserted exp=f"); end
    checks++; if (d0 !== 32'h0190_0190) begin errors++; $display("FAIL stall_data got=%h exp=01900190", d0); end
    rd_ready = 1'b1;
    n = 0;
    while (SPI_cs[1] && n < 100) begin @(negedge clk); n++; end
    checks++; if (n != CLK_DIV + 1) begin errors++; $display("FAIL stall_gap got=%0d exp=%0d", n, CLK_DIV + 1); end
    n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_finish got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    int n, nv;
    rd_ready = 1'b1;
    pulse_start();
    n = 0;
    while (SPI_cs[0] && n < 100) begin @(negedge clk); n++; end
    repeat (CLK_DIV + 16 * 2 * CLK_DIV + 5) @(negedge clk);
    checks++; if (SPI_cs !== 4'hE) begin errors++; $display("FAIL mid_cs_before got=%h exp=e", SPI_cs); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (SPI_cs !== 4'hF || SPI_clk !== 1'b0) begin errors++; $display("FAIL mid_spi got=%h/%b exp=f/0", SPI_cs, SPI_clk); end
    checks++; if (rd_data !== 32'd0 || rd_ch !== 2'd0) begin errors++; $display("FAIL mid_rd got=%h/%0d exp=0/0", rd_data, rd_ch); end
    checks++; if ({rd_valid, rd_fault, rd_absent, busy, overrun} !== 5'd0) begin errors++; $display("FAIL mid_flags got=%b exp=00000", {rd_valid, rd_fault, rd_absent, busy, overrun}); end
    reset = 1'b1;
    nv = 0;
    repeat (1000) begin
      @(negedge clk);
      if (rd_valid) nv++;
    end
    checks++; if (nv != 0 || busy !== 1'b0) begin errors++; $display("FAIL mid_after got=%0d/%b exp=0/0", nv, busy); end
  endtask

  task automatic test_overrun();
    int ov_cnt, ov_first;
    reset_p = 1'b0; ready_p = 1'b0;
    repeat (2) @(negedge clk);
    reset_p = 1'b1; start_p = 1'b1;
    ov_cnt = 0; ov_first = -1;
    for (int n = 1; n <= 2600; n++) begin
      @(negedge clk);
      start_p = 1'b0;
      if (overrun_p) begin
        if (ov_cnt == 0) ov_first = n;
        ov_cnt++;
      end
    end
    checks++; if (ov_cnt != 1) begin errors++; $display("FAIL ovr_count got=%0d exp=1", ov_cnt); end
    checks++; if (ov_first != 2000) begin errors++; $display("FAIL ovr_time got=%0d exp=2000", ov_first); end
    checks++; if ({busy_p, valid_p} !== 2'b11 || ch_p !== 2'd0) begin errors++; $display("FAIL ovr_stalled got=%b/%0d exp=11/0", {busy_p, valid_p}, ch_p); end
  endtask

  initial begin
    for (int i = 0; i < N_CH; i++) begin
      dev_val[i] = 32'd0;
      cs_fall_cnt[i] = 0;
    end
    test_reset();
    test_sweep();
    test_fault();
    test_absent();
    test_stall();
    test_reset_mid();
    test_overrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/max31855_multi_reader.md
# max31855_multi_reader

Multi-channel SPI reader for MAX31855 thermocouple converters sharing one SCK/MISO bus with one active-low chip-select per device. Each sample period it sweeps every channel, shifting in one 32-bit frame per device. It then presents each frame with channel index and decoded status flags on a ready/valid stream, which the downstream UART formatter consumes. It generalises the single-device reader to N_CH channels, a programmable SCK rate and sample period, back-pressure, and absent-device detection.

## Interface
- N_CH, 4, number of devices/chip-selects (1..16)
- CLK_DIV, 10, sys-clock cycles per SCK half-period (>=2)
- SAMPLE_PERIOD, 1000000, sys-clock cycles between sweep starts (must exceed one sweep)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; requests an immediate sweep (same as period tick)
- SPI_clk  out  1  SCK, idle low
- SPI_cs  out  N_CH  active-low chip selects, at most one low at a time
- SPI_Data_In  in  1  MISO shared by all devices
- rd_valid  out  1  frame available
- rd_ready  in  1  consumer accepts frame when rd_valid & rd_ready
- rd_ch  out  $clog2(N_CH) (min 1)  channel index of frame
- rd_data  out  32  raw frame, D31 first bit received
- rd_fault  out  1  frame bit D16
- rd_absent  out  1  frame == 32'hFFFF_FFFF (MISO floating high)
- busy  out  1  sweep in progress
- overrun  out  1  one-cycle pulse when a tick is dropped

## Operation
- FSM: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> OUTPUT -> CS_GAP -> (CS_SETUP for next channel | IDLE after channel N_CH-1).
- IDLE: on period tick or start, channel = 0, busy = 1, go CS_SETUP.
- CS_SETUP: SPI_cs[ch] low, SPI_clk low, for CLK_DIV cycles.
- SHIFT: 32 SCK periods; SPI_clk high for CLK_DIV, low for CLK_DIV. SPI_Data_In is sampled into the shift register (MSB first) on the clk edge that drives SPI_clk high. After the 32nd low phase, go CS_HOLD.
- CS_HOLD: CLK_DIV cycles with CS still low, then CS high. Load rd_data/rd_ch/rd_fault/rd_absent. Go OUTPUT with rd_valid = 1.
- OUTPUT: hold all rd_* stable until rd_ready = 1. The transfer clears rd_valid and goes CS_GAP. No SPI activity while stalled.
- CS_GAP: all CS high for CLK_DIV cycles. Then increment ch or finish (busy = 0).
- Period counter free-runs 0..SAMPLE_PERIOD-1; tick at wrap. A tick or start while busy sets one pending flag, which launches a new sweep from IDLE on the following cycle. A tick/start while pending is already set pulses overrun and is otherwise ignored.
- Frame decode: rd_fault = D16, rd_absent = all ones. When rd_absent = 1, rd_fault is forced 0.

## Timing
- Reset values: SPI_cs all ones, SPI_clk 0, rd_valid 0, rd_data 0, rd_ch 0, rd_fault 0, rd_absent 0, busy 0, overrun 0, pending 0, period counter 0, FSM IDLE.
- Reset asserted mid-frame: CS deasserts and SCK returns low on the next rising edge. The partial frame is discarded and no rd_valid is issued.
- Per-channel latency, from the cycle CS falls to the first rd_valid cycle: CLK_DIV + 64·CLK_DIV + CLK_DIV cycles. With CLK_DIV = 10 this is 660 cycles.
- Consecutive CS-low windows are separated by at least CLK_DIV + 1 cycles of all-high CS, plus any rd_ready stall.
- start coincident with a period tick counts as one request.
- rd_ready high while rd_valid is low has no effect. rd_valid never drops without a handshake.

## Configuration
- MAX_FAULT_RETRY_EN defined: a frame with D16 = 1 and not absent is re-read once. The block goes CS_GAP -> CS_SETUP on the same channel without emitting. The retry frame is emitted whatever its value. Added latency is one frame plus the gap.
- MAX_FAULT_RETRY_EN undefined: every frame is emitted exactly once.

## Test plan
- N_CH = 4, each device model returns 32'h0190_0190 + ch; start pulse -> four frames, rd_ch 0..3, rd_data 32'h0190_0190..32'h0190_0193, rd_fault 0, rd_absent 0, busy low after the 4th handshake.
- Device 2 returns 32'h0001_0001, rd_ready always 1 -> ch 2 rd_fault = 1. With MAX_FAULT_RETRY_EN, ch 2 has two CS-low windows and one emitted frame.
- Channel 1 MISO tied high -> rd_data 32'hFFFF_FFFF, rd_absent = 1, rd_fault = 0.
- Hold rd_ready low 5000 cycles on ch 0 -> rd_* stable, SPI_clk low, all SPI_cs high throughout. Ch 1 CS falls CLK_DIV + 1 cycles after the handshake.
- SAMPLE_PERIOD = 1000 with a stalled consumer -> first tick sets pending, second tick pulses overrun for exactly one cycle.
- Assert reset during bit 15 of ch 0 -> next edge: SPI_cs = 4'hF, SPI_clk = 0. No rd_valid appears, and all outputs equal their reset values.
